// File: rtl/clock_time_digits.sv
// Wall-clock HH:MM:SS in BCD feeding a 4-digit 7-segment scanner.
// Optional LEAD_ZERO_BLANK_EN blanks the hour-tens digit when it is zero.
module clock_time_digits #(
  parameter int TICK_DIV = 50000000,
  parameter int SCAN_DIV = 12500
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RUN,
  input  logic       BTN_MIN,
  input  logic       BTN_HOUR,
  output logic       SCAN_EN,
  output logic       SEC_TICK,
  output logic [7:0] L1,
  output logic [7:0] L2,
  output logic [7:0] L3,
  output logic [7:0] L4
);

  localparam int DW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_MAX  = DW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(TICK_DIV / 2);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [7:0] L4_RST = 8'h00;
`else
  localparam logic [7:0] L4_RST = 8'h3F;
`endif

  function automatic logic [7:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 8'h3F;
      4'd1:    seg = 8'h06;
      4'd2:    seg = 8'h5B;
      4'd3:    seg = 8'h4F;
      4'd4:    seg = 8'h66;
      4'd5:    seg = 8'h6D;
      4'd6:    seg = 8'h7D;
      4'd7:    seg = 8'h07;
      4'd8:    seg = 8'h7F;
      4'd9:    seg = 8'h6F;
      default: seg = 8'h00;
    endcase
  endfunction

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic          sec_tick_q, sec_tick_d;
  logic          scan_en_q, scan_en_d;
  logic [2:0]    sec_t_q, sec_t_d;
  logic [3:0]    sec_o_q, sec_o_d;
  logic [2:0]    min_t_q, min_t_d;
  logic [3:0]    min_o_q, min_o_d;
  logic [1:0]    hr_t_q, hr_t_d;
  logic [3:0]    hr_o_q, hr_o_d;
  logic [7:0]    l1_q, l1_d;
  logic [7:0]    l2_q, l2_d;
  logic [7:0]    l3_q, l3_d;
  logic [7:0]    l4_q, l4_d;

  logic       tick;
  logic       colon;
  logic       sec_wrap, min_wrap, hr_wrap;
  logic [2:0] sec_nt, min_nt;
  logic [3:0] sec_no, min_no, hr_no;
  logic [1:0] hr_nt;

  // Incremented digit pairs, shared by the carry chain and the set buttons.
  always_comb begin
    sec_wrap = (sec_t_q == 3'd5) && (sec_o_q == 4'd9);
    min_wrap = (min_t_q == 3'd5) && (min_o_q == 4'd9);
    hr_wrap  = (hr_t_q == 2'd2) && (hr_o_q == 4'd3);
    sec_nt = sec_t_q;
    sec_no = sec_o_q + 4'd1;
    if (sec_o_q == 4'd9) begin
      sec_no = 4'd0;
      sec_nt = sec_wrap ? 3'd0 : sec_t_q + 3'd1;
    end
    min_nt = min_t_q;
    min_no = min_o_q + 4'd1;
    if (min_o_q == 4'd9) begin
      min_no = 4'd0;
      min_nt = min_wrap ? 3'd0 : min_t_q + 3'd1;
    end
    hr_nt = hr_t_q;
    hr_no = hr_o_q + 4'd1;
    if (hr_wrap) begin
      hr_nt = 2'd0;
      hr_no = 4'd0;
    end else if (hr_o_q == 4'd9) begin
      hr_nt = hr_t_q + 2'd1;
      hr_no = 4'd0;
    end
  end

  always_comb begin
    tick       = RUN && (div_cnt_q == DIV_MAX);
    sec_tick_d = tick;
    div_cnt_d  = div_cnt_q;
    if (RUN)
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    scan_en_d  = (scan_cnt_q == SCAN_MAX);
    scan_cnt_d = scan_en_d ? '0 : scan_cnt_q + 1'b1;

    sec_t_d = sec_t_q;
    sec_o_d = sec_o_q;
    min_t_d = min_t_q;
    min_o_d = min_o_q;
    hr_t_d  = hr_t_q;
    hr_o_d  = hr_o_q;
    // Buttons override a coincident tick's time update.
    if (BTN_MIN || BTN_HOUR) begin
      sec_t_d = 3'd0;
      sec_o_d = 4'd0;
      if (BTN_MIN) begin
        min_t_d = min_nt;
        min_o_d = min_no;
      end
      if (BTN_HOUR) begin
        hr_t_d = hr_nt;
        hr_o_d = hr_no;
      end
    end else if (tick) begin
      sec_t_d = sec_nt;
      sec_o_d = sec_no;
      if (sec_wrap) begin
        min_t_d = min_nt;
        min_o_d = min_no;
        if (min_wrap) begin
          hr_t_d = hr_nt;
          hr_o_d = hr_no;
        end
      end
    end

    colon = (div_cnt_q < DIV_HALF);
    l1_d  = seg(min_o_q);
    l2_d  = seg({1'b0, min_t_q});
    l3_d  = seg(hr_o_q) | {colon, 7'b0};
`ifdef LEAD_ZERO_BLANK_EN
    l4_d  = (hr_t_q == 2'd0) ? 8'h00 : seg({2'b0, hr_t_q});
`else
    l4_d  = seg({2'b0, hr_t_q});
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_cnt_q  <= '0;
      scan_cnt_q <= '0;
      sec_tick_q <= 1'b0;
      scan_en_q  <= 1'b0;
      sec_t_q    <= 3'd0;
      sec_o_q    <= 4'd0;
      min_t_q    <= 3'd0;
      min_o_q    <= 4'd0;
      hr_t_q     <= 2'd0;
      hr_o_q     <= 4'd0;
      l1_q       <= 8'h3F;
      l2_q       <= 8'h3F;
      l3_q       <= 8'h3F;
      l4_q       <= L4_RST;
    end else begin
      div_cnt_q  <= div_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      sec_tick_q <= sec_tick_d;
      scan_en_q  <= scan_en_d;
      sec_t_q    <= sec_t_d;
      sec_o_q    <= sec_o_d;
      min_t_q    <= min_t_d;
      min_o_q    <= min_o_d;
      hr_t_q     <= hr_t_d;
      hr_o_q     <= hr_o_d;
      l1_q       <= l1_d;
      l2_q       <= l2_d;
      l3_q       <= l3_d;
      l4_q       <= l4_d;
    end
  end

  assign SCAN_EN  = scan_en_q;
  assign SEC_TICK = sec_tick_q;
  assign L1       = l1_q;
  assign L2       = l2_q;
  assign L3       = l3_q;
  assign L4       = l4_q;

endmodule

// File: tb/tb_clock_time_digits.sv
// Bench for clock_time_digits: seconds-of-day reference model,
// directed scenarios plus randomized run/button/reset traffic.
module tb_clock_time_digits;

  localparam int TD = 10;
  localparam int SD = 4;

`ifdef LEAD_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif
  localparam logic [7:0] L4_ZERO = BLANK ? 8'h00 : 8'h3F;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RUN = 1'b0;
  logic       BTN_MIN = 1'b0;
  logic       BTN_HOUR = 1'b0;
  logic       SCAN_EN, SEC_TICK;
  logic [7:0] L1, L2, L3, L4;

  clock_time_digits #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
    .CLK(CLK), .RST(RST), .RUN(RUN),
    .BTN_MIN(BTN_MIN), .BTN_HOUR(BTN_HOUR),
    .SCAN_EN(SCAN_EN), .SEC_TICK(SEC_TICK),
    .L1(L1), .L2(L2), .L3(L3), .L4(L4)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail = 0;
  int tick_cnt = 0;
  int scan_cnt = 0;

  int m_t = 0;
  int m_div = 0;
  int m_scan = 0;
  logic       e_tick = 1'b0;
  logic       e_scan = 1'b0;
  logic [7:0] e_l1 = 8'h3F;
  logic [7:0] e_l2 = 8'h3F;
  logic [7:0] e_l3 = 8'h3F;
  logic [7:0] e_l4 = 8'h3F;

  logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                               8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] l4_of(input int h);
    if (BLANK && (h / 10) == 0) return 8'h00;
    return seg_tab[h / 10];
  endfunction

  task automatic model(input bit r, input bit run,
                       input bit bm, input bit bh);
    int h, m;
    bit tk;
    if (r) begin
      m_t = 0; m_div = 0; m_scan = 0;
      e_tick = 0; e_scan = 0;
      e_l1 = 8'h3F; e_l2 = 8'h3F; e_l3 = 8'h3F; e_l4 = L4_ZERO;
      return;
    end
    h = m_t / 3600;
    m = (m_t / 60) % 60;
    e_l1 = seg_tab[m % 10];
    e_l2 = seg_tab[m / 10];
    e_l3 = seg_tab[h % 10] | ((m_div < TD / 2) ? 8'h80 : 8'h00);
    e_l4 = l4_of(h);
    tk = run && (m_div == TD - 1);
    e_tick = tk;
    if (run) m_div = (m_div + 1) % TD;
    e_scan = (m_scan == SD - 1);
    m_scan = (m_scan + 1) % SD;
    if (bm || bh) begin
      if (bm) m = (m + 1) % 60;
      if (bh) h = (h + 1) % 24;
      m_t = h * 3600 + m * 60;
    end else if (tk) begin
      m_t = (m_t + 1) % 86400;
    end
  endtask

  task automatic step(input bit r, input bit run,
                      input bit bm, input bit bh);
    RST = r; RUN = run; BTN_MIN = bm; BTN_HOUR = bh;
    @(posedge CLK);
    model(r, run, bm, bh);
    #1;
    if (SEC_TICK === 1'b1) tick_cnt++;
    if (SCAN_EN === 1'b1) scan_cnt++;
    check("sec_tick", int'(SEC_TICK), int'(e_tick));
    check("scan_en", int'(SCAN_EN), int'(e_scan));
    check("l1", int'(L1), int'(e_l1));
    check("l2", int'(L2), int'(e_l2));
    check("l3", int'(L3), int'(e_l3));
    check("l4", int'(L4), int'(e_l4));
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
  endtask

  initial begin
    // reset state and colon
    do_reset();
    check("rst_l1", int'(L1), 8'h3F);
    check("rst_l2", int'(L2), 8'h3F);
    check("rst_l3", int'(L3), 8'h3F);
    check("rst_l4", int'(L4), int'(L4_ZERO));
    check("rst_tick", int'(SEC_TICK), 0);
    check("rst_scan", int'(SCAN_EN), 0);
    step(0, 0, 0, 0);
    check("rst_colon_on", int'(L3), 8'hBF);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
    check("colon_off", int'(L3), 8'h3F);

    // scan strobe with RUN low
    do_reset();
    scan_cnt = 0;
    tick_cnt = 0;
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0);
    check("scan_pulses", scan_cnt, 3);
    check("scan_no_tick", tick_cnt, 0);

    // midnight rollover
    do_reset();
    for (int i = 0; i < 23; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 59; i++) step(0, 0, 1, 0);
    tick_cnt = 0;
    for (int i = 0; i < 600; i++) step(0, 1, 0, 0);
    check("midnight_ticks", tick_cnt, 60);
    step(0, 0, 0, 0);
    check("midnight_l1", int'(L1), 8'h3F);
    check("midnight_l2", int'(L2), 8'h3F);
    check("midnight_l3", int'(L3), 8'hBF);
    check("midnight_l4", int'(L4), int'(L4_ZERO));

    // set-button wrap
    for (int i = 0; i < 23; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 59; i++) step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    check("minwrap_l1", int'(L1), 8'h3F);
    check("minwrap_l2", int'(L2), 8'h3F);
    check("minwrap_l3", int'(L3 & 8'h7F), 8'h4F);
    check("minwrap_l4", int'(L4), 8'h5B);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check("hrwrap_l3", int'(L3 & 8'h7F), 8'h3F);
    check("hrwrap_l4", int'(L4), int'(L4_ZERO));
    step(0, 0, 1, 1);
    step(0, 0, 0, 0);
    check("both_l1", int'(L1), 8'h06);
    check("both_l3", int'(L3 & 8'h7F), 8'h06);

    // tick collides with BTN_MIN at 00:00:59, then freeze
    do_reset();
    for (int i = 0; i < 599; i++) step(0, 1, 0, 0);
    tick_cnt = 0;
    step(0, 1, 1, 0);
    check("coll_tick", tick_cnt, 1);
    step(0, 0, 0, 0);
    check("coll_l1", int'(L1), 8'h06);
    check("coll_l2", int'(L2), 8'h3F);
    tick_cnt = 0;
    for (int i = 0; i < 50; i++) step(0, 0, 0, 0);
    check("freeze_ticks", tick_cnt, 0);

    // hour tens blanking
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check("h05_l4", int'(L4), int'(L4_ZERO));
    check("h05_l3", int'(L3 & 8'h7F), 8'h6D);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check("h12_l4", int'(L4), 8'h06);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 499) == 0,
           $urandom_range(0, 7) != 0,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 59) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
